// File: rtl/timer_array.sv
// Memory-mapped bank of up-counting timers with per-channel prescaler,
// auto-reload or one-shot mode, and sticky pending flags driving irq.
module timer_array #(
  parameter int CH_NUM = 2,
  parameter int WIDTH = 32,
  parameter int PRESC_W = 8,
  localparam int AW = $clog2(CH_NUM) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     addr,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic [CH_NUM-1:0] irq,
  output logic              irq_any
);

  logic [WIDTH-1:0]   th [CH_NUM];
  logic [WIDTH-1:0]   tl [CH_NUM];
  logic [PRESC_W-1:0] presc [CH_NUM];
  logic [PRESC_W-1:0] pcnt [CH_NUM];

  logic [CH_NUM-1:0] en, ie, mode, pend;
  logic [CH_NUM-1:0] sel, tick, ovf, clr_pc;
  logic [CH_NUM-1:0] wr_th, wr_tl, wr_tcon, wr_presc;
  logic [31:0]       ch;
  logic [WIDTH-1:0]  rd_nxt;

  assign ch = 32'(addr >> 2);

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      sel[i]      = wr_en && (ch == 32'(i));
      wr_th[i]    = sel[i] && (addr[1:0] == 2'd0);
      wr_tl[i]    = sel[i] && (addr[1:0] == 2'd1);
      wr_tcon[i]  = sel[i] && (addr[1:0] == 2'd2);
      wr_presc[i] = sel[i] && (addr[1:0] == 2'd3);
      tick[i]     = en[i] && (pcnt[i] == presc[i]);
      ovf[i]      = tick[i] && (&tl[i]);
      // pcnt sits at 0 whenever the channel is, or is about to be, stopped
      clr_pc[i]   = !en[i] || tick[i] || wr_presc[i]
                    || (wr_tcon[i] && !wr_data[0]);
    end
  end

  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (ch == 32'(i)) begin
        case (addr[1:0])
          2'd0: rd_nxt = th[i];
          2'd1: rd_nxt = tl[i];
          2'd2: rd_nxt = WIDTH'({pend[i], mode[i], ie[i], en[i]});
          default: rd_nxt = WIDTH'(presc[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH_NUM; i++) begin
        th[i]    <= '0;
        tl[i]    <= '0;
        presc[i] <= '0;
        pcnt[i]  <= '0;
      end
      en      <= '0;
      ie      <= '0;
      mode    <= '0;
      pend    <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= rd_nxt;
      for (int i = 0; i < CH_NUM; i++) begin
        pcnt[i] <= clr_pc[i] ? '0 : pcnt[i] + PRESC_W'(1);
        if (wr_th[i])
          th[i] <= wr_data;
        // bus write beats the count; reload uses the pre-edge TH
        if (wr_tl[i])
          tl[i] <= wr_data;
        else if (ovf[i])
          tl[i] <= th[i];
        else if (tick[i])
          tl[i] <= tl[i] + WIDTH'(1);
        if (wr_presc[i])
          presc[i] <= wr_data[PRESC_W-1:0];
        if (wr_tcon[i]) begin
          en[i]   <= wr_data[0];
          ie[i]   <= wr_data[1];
          mode[i] <= wr_data[2];
        end else if (ovf[i] && mode[i]) begin
          en[i] <= 1'b0;
        end
        if (ovf[i])
          pend[i] <= 1'b1;
        else if (wr_tcon[i] && wr_data[3])
          pend[i] <= 1'b0;
      end
    end
  end

  assign irq     = pend & ie;
  assign irq_any = |irq;

endmodule

// File: tb/tb_timer_array.sv
// Bench for timer_array: fixed vector table, directed corner sequences,
// then random traffic against a per-channel reference model.
module tb_timer_array;

  localparam int CH = 3;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          wr_en = 1'b0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic [CH-1:0] irq;
  logic          irq_any;

  timer_array #(.CH_NUM(CH), .WIDTH(32), .PRESC_W(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data), .irq(irq), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit [31:0] m_th [CH];
  bit [31:0] m_tl [CH];
  bit [7:0]  m_presc [CH];
  bit [7:0]  m_pcnt [CH];
  bit        m_en [CH];
  bit        m_ie [CH];
  bit        m_mode [CH];
  bit        m_pend [CH];
  bit [31:0] m_rd;

  typedef struct {
    int        a;
    bit        we;
    bit [31:0] wd;
    bit [31:0] rd;
    bit [2:0]  irq;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit [31:0] m_read(int c, int r);
    if (c >= CH) return 0;
    case (r)
      0: return m_th[c];
      1: return m_tl[c];
      2: return {28'd0, m_pend[c], m_mode[c], m_ie[c], m_en[c]};
      default: return {24'd0, m_presc[c]};
    endcase
  endfunction

  function automatic bit [CH-1:0] m_irq();
    bit [CH-1:0] v;
    for (int k = 0; k < CH; k++) v[k] = m_pend[k] && m_ie[k];
    return v;
  endfunction

  task automatic step_model(bit rst, int a, bit we, bit [31:0] wd);
    int c = a / 4;
    int r = a % 4;
    m_rd = rst ? 0 : m_read(c, r);
    for (int k = 0; k < CH; k++) begin
      bit ticked, wrap, hit, ne, np;
      bit [31:0] ntl;
      bit [7:0]  pc;
      if (rst) begin
        m_th[k] = 0; m_tl[k] = 0; m_presc[k] = 0; m_pcnt[k] = 0;
        m_en[k] = 0; m_ie[k] = 0; m_mode[k] = 0; m_pend[k] = 0;
        continue;
      end
      ticked = m_en[k] && (m_pcnt[k] == m_presc[k]);
      wrap   = ticked && (m_tl[k] == 32'hFFFF_FFFF);
      ntl    = !ticked ? m_tl[k] : (wrap ? m_th[k] : m_tl[k] + 1);
      np     = m_pend[k] || wrap;
      ne     = m_en[k] && !(wrap && m_mode[k]);
      pc     = (m_en[k] && !ticked) ? m_pcnt[k] + 8'd1 : 8'd0;
      hit    = we && (c == k);
      if (hit) begin
        case (r)
          0: m_th[k] = wd;
          1: ntl = wd;
          2: begin
            ne = wd[0];
            m_ie[k] = wd[1];
            m_mode[k] = wd[2];
            if (wd[3] && !wrap) np = 0;
          end
          default: begin
            m_presc[k] = wd[7:0];
            pc = 0;
          end
        endcase
      end
      if (!ne) pc = 0;
      m_tl[k] = ntl;
      m_pend[k] = np;
      m_en[k] = ne;
      m_pcnt[k] = pc;
    end
  endtask

  task automatic cyc(bit rst, int a, bit we, bit [31:0] wd);
    reset = rst;
    addr = AW'(a);
    wr_en = we;
    wr_data = wd;
    step_model(rst, a, we, wd);
    @(posedge clk);
    #1;
    chk("model_rd", rd_data, m_rd);
    chk("model_irq", 32'(irq), 32'(m_irq()));
    chk("model_any", 32'(irq_any), 32'(|m_irq()));
    reset = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic wr(int a, bit [31:0] d);
    cyc(0, a, 1, d);
  endtask

  task automatic rd(int a);
    cyc(0, a, 0, 0);
  endtask

  initial begin
    tbl[0]  = '{0, 1, 32'hFFFF_FFFD, 32'h0, 3'b000};
    tbl[1]  = '{1, 1, 32'hFFFF_FFFD, 32'h0, 3'b000};
    tbl[2]  = '{3, 1, 32'h0, 32'h0, 3'b000};
    tbl[3]  = '{2, 1, 32'h3, 32'h0, 3'b000};
    tbl[4]  = '{1, 0, 32'h0, 32'hFFFF_FFFD, 3'b000};
    tbl[5]  = '{1, 0, 32'h0, 32'hFFFF_FFFE, 3'b000};
    tbl[6]  = '{1, 0, 32'h0, 32'hFFFF_FFFF, 3'b001};
    tbl[7]  = '{1, 0, 32'h0, 32'hFFFF_FFFD, 3'b001};
    tbl[8]  = '{2, 0, 32'h0, 32'hB, 3'b001};
    tbl[9]  = '{1, 0, 32'h0, 32'hFFFF_FFFF, 3'b001};
    tbl[10] = '{1, 0, 32'h0, 32'hFFFF_FFFD, 3'b001};
    tbl[11] = '{2, 1, 32'h8, 32'hB, 3'b000};
    tbl[12] = '{1, 0, 32'h0, 32'hFFFF_FFFF, 3'b000};
    tbl[13] = '{1, 0, 32'h0, 32'hFFFF_FFFF, 3'b000};

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_rd", rd_data, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    for (int i = 0; i < 14; i++) begin
      cyc(0, tbl[i].a, tbl[i].we, tbl[i].wd);
      chk("tbl_rd", rd_data, tbl[i].rd);
      chk("tbl_irq", 32'(irq), 32'(tbl[i].irq));
    end

    // one-shot with prescale 3 on ch1
    wr(4, 32'h1234);
    wr(5, 32'hFFFF_FFFF);
    wr(7, 3);
    wr(6, 7);
    rd(5); rd(5); rd(5);
    chk("os_early", 32'(irq[1]), 32'h0);
    rd(5);
    chk("os_irq", 32'(irq[1]), 32'h1);
    chk("os_any", 32'(irq_any), 32'h1);
    rd(5);
    chk("os_tl", rd_data, 32'h1234);
    rd(6);
    chk("os_tcon", rd_data, 32'hE);
    rd(5); rd(5);
    chk("os_frozen", rd_data, 32'h1234);
    wr(6, 8);

    // ch0 overflows every tick with TH all-ones
    wr(0, 32'hFFFF_FFFF);
    wr(1, 32'hFFFF_FFFF);
    wr(2, 3);
    rd(2);
    chk("w1c_set", 32'(irq[0]), 32'h1);
    wr(2, 32'hB);
    chk("w1c_collide", 32'(irq[0]), 32'h1);
    wr(0, 0);
    rd(1);
    chk("th_collide", rd_data, 32'hFFFF_FFFF);
    rd(1);
    chk("wrap_th0", rd_data, 32'h0);
    wr(2, 32'hB);
    chk("w1c_clear", 32'(irq[0]), 32'h0);
    wr(2, 0);

    // polling on ch2 with IE=0
    wr(9, 32'hFFFF_FFFF);
    wr(10, 1);
    rd(10);
    chk("poll_noirq", 32'(irq[2]), 32'h0);
    rd(10);
    chk("poll_pend", rd_data, 32'h9);
    wr(10, 3);
    chk("poll_ie", 32'(irq[2]), 32'h1);
    wr(10, 8);

    // TL write on a tick edge, then out-of-range channel
    wr(2, 1);
    wr(1, 32'h55);
    rd(1);
    chk("tl_tick_wr", rd_data, 32'h55);
    rd(1);
    chk("tl_after", rd_data, 32'h56);
    wr(2, 0);
    wr(13, 32'hDEAD);
    wr(14, 32'hF);
    rd(13);
    chk("oor_rd13", rd_data, 32'h0);
    rd(14);
    chk("oor_rd14", rd_data, 32'h0);
    rd(1);
    chk("oor_nochg", rd_data, 32'h58);

    // reset while counting with PEND set
    wr(1, 32'hFFFF_FFFF);
    wr(2, 3);
    rd(1);
    chk("pre_rst_irq", 32'(irq[0]), 32'h1);
    cyc(1, 1, 0, 0);
    chk("rst_irq0", 32'(irq), 32'h0);
    chk("rst_any0", 32'(irq_any), 32'h0);
    cyc(1, 1, 0, 0);
    for (int a = 0; a < 12; a++) begin
      rd(a);
      chk("rst_reg", rd_data, 32'h0);
    end
    rd(1);
    chk("rst_tl_hold", rd_data, 32'h0);

    for (int n = 0; n < 800; n++) begin
      int a;
      bit we;
      bit rst;
      bit [31:0] d;
      a = $urandom_range(0, 15);
      we = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 199) == 0);
      case (a % 4)
        0: d = $urandom_range(0, 1) ? $urandom
               : (32'hFFFF_FFF0 | $urandom_range(0, 15));
        1: d = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        2: d = $urandom_range(0, 15);
        default: d = $urandom_range(0, 3);
      endcase
      cyc(rst, a, we, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
